debounce_bank: RTL

DEBOUNCE_BANK -- requirements
Module: debounce_bank

---
 rtl/debounce_bank.sv | 107 ++++++++++
 1 files changed

// File: rtl/debounce_bank.sv
`default_nettype none
// ============================================================================
// Module      : debounce_bank
// Description : WIDTH independent tick-paced debouncers with rise/fall/changed
//               pulses. Define DEBOUNCE_SYNC_EN to add a 2-flop input
//               synchroniser per channel.
// Revision    : 1.0 - initial release
// ============================================================================
module debounce_bank #(
    parameter int               WIDTH     = 4,
    parameter int               STABLE    = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             tick,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic             changed
);

    localparam int               CNT_W  = $clog2(STABLE + 1);
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(STABLE - 1);
    localparam logic [CNT_W-1:0] C_ONE  = CNT_W'(1);

    logic [WIDTH-1:0] w_samp;

`ifdef DEBOUNCE_SYNC_EN
    logic [WIDTH-1:0] r_sync1;
    logic [WIDTH-1:0] r_sync2;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1 <= RESET_VAL;
            r_sync2 <= RESET_VAL;
        end else begin
            r_sync1 <= in;
            r_sync2 <= r_sync1;
        end
    end

    assign w_samp = r_sync2;
`else
    assign w_samp = in;
`endif

    logic [CNT_W-1:0] r_cnt     [WIDTH];
    logic [CNT_W-1:0] w_cnt_nxt [WIDTH];
    logic [WIDTH-1:0] r_out;
    logic [WIDTH-1:0] w_out_nxt;
    logic [WIDTH-1:0] r_rise;
    logic [WIDTH-1:0] r_fall;
    logic [WIDTH-1:0] w_rise_nxt;
    logic [WIDTH-1:0] w_fall_nxt;
    logic             r_changed;

    // The accepting edge clears the counter, so it never passes STABLE-1.
    always_comb begin
        w_out_nxt  = r_out;
        w_rise_nxt = '0;
        w_fall_nxt = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_cnt_nxt[i] = r_cnt[i];
            if (tick) begin
                if (w_samp[i] == r_out[i]) begin
                    w_cnt_nxt[i] = '0;
                end else if (r_cnt[i] == C_LAST) begin
                    w_cnt_nxt[i]  = '0;
                    w_out_nxt[i]  = w_samp[i];
                    w_rise_nxt[i] = w_samp[i];
                    w_fall_nxt[i] = ~w_samp[i];
                end else begin
                    w_cnt_nxt[i] = r_cnt[i] + C_ONE;
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < WIDTH; i++) begin
                r_cnt[i] <= '0;
            end
            r_out     <= RESET_VAL;
            r_rise    <= '0;
            r_fall    <= '0;
            r_changed <= 1'b0;
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                r_cnt[i] <= w_cnt_nxt[i];
            end
            r_out     <= w_out_nxt;
            r_rise    <= w_rise_nxt;
            r_fall    <= w_fall_nxt;
            r_changed <= |(w_rise_nxt | w_fall_nxt);
        end
    end

    assign out     = r_out;
    assign rise    = r_rise;
    assign fall    = r_fall;
    assign changed = r_changed;

endmodule
`default_nettype wire
